// File: rtl/mdio_reg_if_arbiter.sv
// mdio_reg_if_arbiter
//   Shares one register-bank interface (reg_if_*) between NUM_REQ register
//   masters (e.g. MDIO clause-22/45 backend and a host/debug port).
//   Round-robin grant, one outstanding transaction, request latched at grant,
//   watchdog aborts transactions the bank never acknowledges.
// Ports
//   clk_25m, rst          : clock, synchronous active-high reset
//   req_valid/we/addr/wdata: per-requester request (addr/wdata packed, slot i at i*W)
//   req_ready/req_err      : one-cycle completion / timeout pulse to the granted requester
//   req_rdata              : shared response data, valid with req_ready
//   reg_if_valid/we/addr/wdata : downstream request, stable while valid
//   reg_if_rdata/ready     : downstream response
//   busy, grant_id         : FSM not idle, current/last granted requester
module mdio_reg_if_arbiter #(
    parameter int unsigned       NUM_REQ     = 2,
    parameter int unsigned       ADDR_W      = 21,
    parameter int unsigned       DATA_W      = 16,
    parameter int unsigned       TIMEOUT_CYC = 255,
    parameter logic [DATA_W-1:0] ERR_RDATA   = 16'hDEAD,
    localparam int unsigned      GNT_W       = $clog2(NUM_REQ)
) (
    input  logic                      clk_25m,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_err,
    output logic [DATA_W-1:0]         req_rdata,
    output logic                      reg_if_valid,
    output logic                      reg_if_we,
    output logic [ADDR_W-1:0]         reg_if_addr,
    output logic [DATA_W-1:0]         reg_if_wdata,
    input  logic [DATA_W-1:0]         reg_if_rdata,
    input  logic                      reg_if_ready,
    output logic                      busy,
    output logic [GNT_W-1:0]          grant_id
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GNT_W-1:0]   r_rr;
    logic [GNT_W-1:0]   r_grant;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_err;

    logic               w_any;
    logic [GNT_W-1:0]   w_pick;
    int unsigned        w_idx;
    logic               w_timeout;
    logic [GNT_W-1:0]   w_rr_nxt;

    // First valid requester at or above the rr pointer, wrapping around.
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_rr;
        w_idx  = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = 32'(r_rr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            if (!w_any && req_valid[GNT_W'(w_idx)]) begin
                w_any  = 1'b1;
                w_pick = GNT_W'(w_idx);
            end
        end
    end

    // TIMEOUT_CYC == 0 disables the watchdog entirely.
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign w_rr_nxt  = (r_grant == GNT_W'(NUM_REQ - 1)) ? '0 : r_grant + GNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_REQ;
            S_REQ:   if (reg_if_ready || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_25m) begin
        if (rst) begin
            r_rr         <= '0;
            r_grant      <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            reg_if_valid <= 1'b0;
            reg_if_we    <= 1'b0;
            reg_if_addr  <= '0;
            reg_if_wdata <= '0;
            req_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant      <= w_pick;
                        r_cnt        <= '0;
                        r_err        <= 1'b0;
                        reg_if_valid <= 1'b1;
                        reg_if_we    <= req_we[w_pick];
                        reg_if_addr  <= req_addr[w_pick*ADDR_W +: ADDR_W];
                        reg_if_wdata <= req_wdata[w_pick*DATA_W +: DATA_W];
                    end
                end
                S_REQ: begin
                    // Ready has priority over a coinciding timeout.
                    if (reg_if_ready) begin
                        req_rdata    <= reg_if_rdata;
                        reg_if_valid <= 1'b0;
                    end else if (w_timeout) begin
                        req_rdata    <= ERR_RDATA;
                        r_err        <= 1'b1;
                        reg_if_valid <= 1'b0;
                    end else if (TIMEOUT_CYC != 0) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_rr <= w_rr_nxt;
                end
                default: ;
            endcase
        end
    end

    // Response pulses decode from registered state only.
    always_comb begin
        req_ready = '0;
        req_err   = '0;
        if (r_state == S_RESP) begin
            req_ready[r_grant] = 1'b1;
            req_err[r_grant]   = r_err;
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign grant_id = r_grant;

endmodule
